// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_cmd_pkg                                               |
// | Description : Shared definitions for the UART command controllers:       |
// |               read-controller state encoding, ASCII command words and    |
// |               default BRAM geometry.                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package uart_cmd_pkg;

    // Default BRAM geometry
    localparam int DEPTH_DEF  = 1024;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    // Command words as they sit in the 24-bit shift register (oldest byte high)
    localparam logic [23:0] CMD_READ  = {8'h72, 8'h64, 8'h0A};  // "rd\n"
    localparam logic [23:0] CMD_WRITE = {8'h77, 8'h61, 8'h0A};  // "wa\n"

    // Read-controller state encoding; values are visible on the status port
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LATCH     = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_ACK  = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_CKSUM     = 3'd6
    } rd_state_e;

endpackage : uart_cmd_pkg
`default_nettype wire

// File: rtl/cmd_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cmd_detect                                                 |
// | Description : 24-bit byte shift register with a fixed-word comparator.   |
// |               Each received byte shifts in at the low end; match_o is    |
// |               high while the last three bytes equal CMD.                 |
// | Revision    : 1.0 - initial release                                      |
// | Ports       : clk, rst     - clock, synchronous active-high reset        |
// |               rx_byte_i    - received byte                               |
// |               rx_valid_i   - one-cycle strobe qualifying rx_byte_i       |
// |               clear_i      - zero the register (wins over rx_valid_i)    |
// |               match_o      - register equals CMD                         |
// +--------------------------------------------------------------------------+
module cmd_detect #(
    parameter logic [23:0] CMD = 24'h000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte_i,
    input  logic       rx_valid_i,
    input  logic       clear_i,
    output logic       match_o
);

    logic [23:0] cmd_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cmd_q <= 24'h000000;
        end else if (rx_valid_i) begin
            cmd_q <= {cmd_q[15:0], rx_byte_i};
        end
    end

    // Compare the registered value only, so a byte arriving this cycle
    // cannot influence the current decision.
    assign match_o = (cmd_q == CMD);

endmodule : cmd_detect
`default_nettype wire

// File: rtl/read_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : read_controller                                            |
// | Description : Waits for "rd\n" on the UART RX stream, then reads every   |
// |               BRAM byte in address order and hands each one to the UART  |
// |               transmitter through a start/busy handshake.                |
// | Revision    : 1.0 - initial release                                      |
// | Option      : READ_CHECKSUM_EN - append an XOR checksum byte after the   |
// |               data bytes (DEPTH+1 bytes per dump).                       |
// | Ports       : clk, rst          - clock, synchronous active-high reset   |
// |               byte_received     - UART RX byte                           |
// |               rx_data_ready     - strobe qualifying byte_received        |
// |               dout              - BRAM read data (1 cycle after en)      |
// |               tx_busy           - UART TX busy                           |
// |               en, addr          - BRAM read port                         |
// |               tx_start, tx_data - UART TX request and byte               |
// |               busy              - controller not idle                    |
// |               status            - current state encoding                 |
// +--------------------------------------------------------------------------+
module read_controller
    import uart_cmd_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_received,
    input  logic              rx_data_ready,
    input  logic [DATA_W-1:0] dout,
    input  logic              tx_busy,
    output logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic [2:0]        status
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rd_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              en_q;
    logic              match;
    logic              cmd_clear;

`ifdef READ_CHECKSUM_EN
    logic [DATA_W-1:0] cksum_q;
    logic              cksum_phase_q;   // the byte in flight is the checksum
`endif

    // The register is wiped on the same edge the FSM leaves IDLE, so one
    // command produces exactly one dump.
    assign cmd_clear = (state_q == ST_IDLE) && match;

    cmd_detect #(
        .CMD (CMD_READ)
    ) u_cmd_detect (
        .clk        (clk),
        .rst        (rst),
        .rx_byte_i  (byte_received),
        .rx_valid_i (rx_data_ready),
        .clear_i    (cmd_clear),
        .match_o    (match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            tx_data_q <= '0;
            en_q      <= 1'b0;
`ifdef READ_CHECKSUM_EN
            cksum_q       <= '0;
            cksum_phase_q <= 1'b0;
`endif
        end else begin
            // en is a one-cycle pulse raised on every entry into FETCH
            en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (match) begin
                        state_q <= ST_FETCH;
                        addr_q  <= '0;
                        en_q    <= 1'b1;
`ifdef READ_CHECKSUM_EN
                        cksum_q       <= '0;
                        cksum_phase_q <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    tx_data_q <= dout;
`ifdef READ_CHECKSUM_EN
                    cksum_q   <= cksum_q ^ dout;
`endif
                    state_q   <= ST_SEND;
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        state_q <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
`ifdef READ_CHECKSUM_EN
                        if (cksum_phase_q) begin
                            cksum_phase_q <= 1'b0;
                            state_q       <= ST_IDLE;
                        end else if (addr_q == LAST_ADDR) begin
                            addr_q  <= '0;
                            state_q <= ST_CKSUM;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            en_q    <= 1'b1;
                            state_q <= ST_FETCH;
                        end
`else
                        if (addr_q == LAST_ADDR) begin
                            addr_q  <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            en_q    <= 1'b1;
                            state_q <= ST_FETCH;
                        end
`endif
                    end
                end
`ifdef READ_CHECKSUM_EN
                ST_CKSUM: begin
                    tx_data_q     <= cksum_q;
                    cksum_phase_q <= 1'b1;
                    state_q       <= ST_SEND;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The start pulse must coincide with the SEND cycle that sees tx_busy
    // low, so it is decoded from the state register rather than delayed.
    assign tx_start = (state_q == ST_SEND) && !tx_busy;

    assign en      = en_q;
    assign addr    = addr_q;
    assign tx_data = tx_data_q;
    assign busy    = (state_q != ST_IDLE);
    assign status  = state_q;

endmodule : read_controller
`default_nettype wire
